// File: rtl/ntt_core_param.sv
// ntt_core_param
//   Parametrised single-buffer streaming NTT engine. A frame of N residues
//   is loaded in bit-reversed order, transformed in place by one iterative
//   Cooley-Tukey butterfly (one butterfly per cycle), then streamed out in
//   natural order. The inverse transform uses OMEGA_INV twiddles and scales
//   each result by N_INV on the way out.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-high reset
//   in_data   in   W  input sample (any value, reduced mod Q on entry)
//   in_valid  in   1  in_data is valid
//   in_ready  out  1  core accepts a sample this cycle (LOAD only)
//   inverse   in   1  0 = forward, 1 = inverse; sampled on beat 0 of a frame
//   out_data  out  W  result sample, always < Q
//   out_valid out  1  out_data is valid (UNLOAD)
//   out_ready in   1  downstream accepts out_data
//   out_last  out  1  marks result index N-1
//   busy      out  1  high during COMPUTE and UNLOAD
module ntt_core_param #(
  parameter int unsigned     W         = 32,
  parameter int unsigned     N         = 8,
  parameter longint unsigned Q         = 7681,
  parameter longint unsigned OMEGA     = 1213,
  parameter longint unsigned OMEGA_INV = 1925,
  parameter longint unsigned N_INV     = 6721
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  localparam int LOGN = $clog2(N);

  localparam logic [W-1:0]    Q_W        = W'(Q);
  localparam logic [W-1:0]    NINV_W     = W'(N_INV);
  localparam logic [LOGN-1:0] LAST_IDX   = LOGN'(N - 1);
  localparam logic [LOGN-1:0] LAST_BF    = LOGN'(N / 2 - 1);
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE_IDX    = LOGN'(1);

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  state_t state, state_nxt;

  logic [LOGN-1:0] load_cnt;
  logic [LOGN-1:0] bf_cnt;
  logic [LOGN-1:0] stage_cnt;
  logic [LOGN-1:0] out_cnt;
  logic            mode_inv;

  logic [W-1:0] mem [N];

  // Modular exponentiation evaluated at elaboration for the twiddle tables.
  function automatic logic [W-1:0] pow_mod(input longint unsigned base, input int unsigned e);
    longint unsigned r;
    r = 1;
    for (int unsigned k = 0; k < e; k++) begin
      r = (r * base) % Q;
    end
    return W'(r);
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) begin
      r[b] = v[LOGN-1-b];
    end
    return r;
  endfunction

  // Constant twiddle tables: entry e holds root^e mod Q. Only the lower
  // N/2 entries are ever addressed; the table is sized N to share the
  // index width with the other counters.
  logic [W-1:0] tw_fwd [N];
  logic [W-1:0] tw_inv [N];

  for (genvar e = 0; e < N; e++) begin : g_tw
    assign tw_fwd[e] = pow_mod(OMEGA, e);
    assign tw_inv[e] = pow_mod(OMEGA_INV, e);
  end

  // Butterfly addressing. For stage s the half-span is 2^s; butterfly k
  // sits in group k>>s at offset k mod 2^s. The upper operand is the lower
  // one with the half-span bit set, and the twiddle exponent is the offset
  // scaled by N/len = 2^(LOGN-1-s).
  logic [LOGN-1:0] half_bit, half_mask, pos, idx_a, idx_b, tw_idx;

  assign half_bit  = ONE_IDX << stage_cnt;
  assign half_mask = half_bit - ONE_IDX;
  assign pos       = bf_cnt & half_mask;
  assign idx_a     = ((bf_cnt & ~half_mask) << 1) | pos;
  assign idx_b     = idx_a | half_bit;
  assign tw_idx    = pos << (LAST_STAGE - stage_cnt);

  // Butterfly datapath. Sum and difference carry one extra bit so that a
  // modulus close to 2^W cannot overflow before the conditional subtract.
  logic [W-1:0]   op_a, op_b, tw, t_mod, new_a, new_b;
  logic [2*W-1:0] prod;
  logic [W:0]     sum, diff;

  assign op_a  = mem[idx_a];
  assign op_b  = mem[idx_b];
  assign tw    = mode_inv ? tw_inv[tw_idx] : tw_fwd[tw_idx];
  assign prod  = {{W{1'b0}}, tw} * {{W{1'b0}}, op_b};
  assign t_mod = W'(prod % {{W{1'b0}}, Q_W});
  assign sum   = {1'b0, op_a} + {1'b0, t_mod};
  assign diff  = {1'b0, op_a} + {1'b0, Q_W} - {1'b0, t_mod};
  assign new_a = (sum  >= {1'b0, Q_W}) ? W'(sum  - {1'b0, Q_W}) : W'(sum);
  assign new_b = (diff >= {1'b0, Q_W}) ? W'(diff - {1'b0, Q_W}) : W'(diff);

  // Output scaling for the inverse transform.
  logic [2*W-1:0] out_prod;
  logic [W-1:0]   out_scaled;

  assign out_prod   = {{W{1'b0}}, mem[out_cnt]} * {{W{1'b0}}, NINV_W};
  assign out_scaled = W'(out_prod % {{W{1'b0}}, Q_W});

  logic in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. in_ready is gated by rst so that it reads
  // low while reset is held and rises as soon as reset is released.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = ~rst;
        if (in_valid && ~rst && load_cnt == LAST_IDX) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (bf_cnt == LAST_BF && stage_cnt == LAST_STAGE) begin
          state_nxt = UNLOAD;
        end
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (out_cnt == LAST_IDX);
        out_data  = mode_inv ? out_scaled : mem[out_cnt];
        if (out_ready && out_cnt == LAST_IDX) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Frame counters and the latched transform direction. Counters are N or
  // N/2 long with N a power of two, so the load and unload counters wrap
  // back to zero naturally after their last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= '0;
      bf_cnt    <= '0;
      stage_cnt <= '0;
      out_cnt   <= '0;
      mode_inv  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (load_cnt == '0) begin
              mode_inv <= inverse;
            end
            load_cnt <= load_cnt + ONE_IDX;
          end
        end
        COMPUTE: begin
          if (bf_cnt == LAST_BF) begin
            bf_cnt    <= '0;
            stage_cnt <= (stage_cnt == LAST_STAGE) ? '0 : stage_cnt + ONE_IDX;
          end else begin
            bf_cnt <= bf_cnt + ONE_IDX;
          end
        end
        UNLOAD: begin
          if (out_fire) begin
            out_cnt <= out_cnt + ONE_IDX;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample buffer. Contents are don't-care after reset, so it carries no
  // reset. Loading writes in bit-reversed order so that the in-place
  // decimation-in-time passes leave results in natural order.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_fire) begin
      mem[bitrev(load_cnt)] <= in_data % Q_W;
    end else if (state == COMPUTE) begin
      mem[idx_a] <= new_a;
      mem[idx_b] <= new_b;
    end
  end

endmodule

// File: tb/tb_ntt_core_param.sv
// tb_ntt_core_param
//   Self-checking bench for ntt_core_param at N=8, Q=7681. Expected results
//   come from a direct O(N^2) DFT over GF(Q), plus a few fixed result tables.
//   Frames are driven with optional random input gaps and output stalls.
module tb_ntt_core_param;

  localparam int W = 32;
  localparam int N = 8;
  localparam int LOGN = 3;
  localparam int COMPUTE_CYCLES = LOGN * N / 2;
  localparam longint unsigned Q = 7681;
  localparam longint unsigned OMEGA = 1213;
  localparam longint unsigned OMEGA_INV = 1925;
  localparam longint unsigned N_INV = 6721;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         inverse;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int lat;

  logic [W-1:0] frame_in [N];
  logic [W-1:0] exp_out  [N];
  logic [W-1:0] got_out  [N];
  logic [W-1:0] orig     [N];
  logic [W-1:0] delta_exp [N] = '{1, 1213, 4298, 5756, 7680, 6468, 3383, 1925};

  ntt_core_param #(
    .W(W), .N(N), .Q(Q), .OMEGA(OMEGA), .OMEGA_INV(OMEGA_INV), .N_INV(N_INV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .inverse(inverse),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Hard time limit in case the DUT wedges somewhere not covered by a bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned powMod(input longint unsigned b, input int e);
    longint unsigned r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % Q;
    return r;
  endfunction

  // Direct DFT over GF(Q): X[k] = sum_n x[n] * root^(n*k), scaled by N^-1 for inverse.
  task automatic computeModel(input bit inv);
    longint unsigned root;
    longint unsigned acc;
    root = inv ? OMEGA_INV : OMEGA;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int n = 0; n < N; n++) begin
        acc = (acc + (longint'(frame_in[n]) % Q) * powMod(root, (n * k) % N)) % Q;
      end
      if (inv) acc = (acc * N_INV) % Q;
      exp_out[k] = W'(acc);
    end
  endtask

  task automatic loadFrame(input bit inv, input int gap_pct);
    int k = 0;
    int cyc = 0;
    bit fire;
    while (k < N && cyc < 500) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = frame_in[k];
      inverse  = (k == 0) ? inv : 1'($urandom);
      fire     = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (fire) k++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (k < N) checkOutput("load_timeout", k, N);
  endtask

  task automatic waitCompute();
    lat = 0;
    checkOutput("busy_compute", busy, 1);
    checkOutput("in_ready_compute", in_ready, 0);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, COMPUTE_CYCLES);
  endtask

  task automatic unloadFrame(input int stall_pct);
    int j = 0;
    int cyc = 0;
    bit fire;
    while (j < N && cyc < 500) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      checkOutput("out_valid", out_valid, 1);
      checkOutput($sformatf("out_data[%0d]", j), out_data, exp_out[j]);
      checkOutput($sformatf("out_last[%0d]", j), out_last, (j == N - 1));
      got_out[j] = out_data;
      fire = out_ready && out_valid;
      @(negedge clk);
      cyc++;
      if (fire) j++;
    end
    out_ready = 1'b0;
    if (j < N) checkOutput("unload_timeout", j, N);
    checkOutput("out_valid_after", out_valid, 0);
    checkOutput("in_ready_after", in_ready, 1);
  endtask

  task automatic applyStimulus(input bit inv, input int gap_pct, input int stall_pct);
    computeModel(inv);
    loadFrame(inv, gap_pct);
    waitCompute();
    unloadFrame(stall_pct);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_out_last"}, out_last, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic randomFrame();
    for (int n = 0; n < N; n++) begin
      frame_in[n] = $urandom_range(1) ? $urandom : W'($urandom_range(7680));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    inverse   = 1'b0;
    out_ready = 1'b0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_release", in_ready, 1);

    // Impulse: all outputs equal the impulse amplitude.
    frame_in = '{5, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(1'b0, 0, 0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("impulse[%0d]", k), got_out[k], 5);

    // Constant input concentrates into bin 0.
    frame_in = '{1, 1, 1, 1, 1, 1, 1, 1};
    applyStimulus(1'b0, 0, 0);
    checkOutput("const_bin0", got_out[0], 8);
    checkOutput("const_bin5", got_out[5], 0);

    // Shifted delta yields successive powers of OMEGA.
    frame_in = '{0, 1, 0, 0, 0, 0, 0, 0};
    applyStimulus(1'b0, 0, 0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("delta[%0d]", k), got_out[k], delta_exp[k]);

    // Round trip, first clean, then with input gaps and output stalls.
    for (int pass = 0; pass < 2; pass++) begin
      frame_in = '{5569, 3457, 1345, 6914, 4802, 2690, 578, 6147};
      orig = frame_in;
      applyStimulus(1'b0, pass * 30, pass * 40);
      frame_in = got_out;
      applyStimulus(1'b1, pass * 30, pass * 40);
      for (int k = 0; k < N; k++) checkOutput($sformatf("roundtrip%0d[%0d]", pass, k), got_out[k], orig[k]);
    end

    // Input reduction and inverse of a single bin.
    frame_in = '{7684, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(1'b0, 0, 0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("reduce[%0d]", k), got_out[k], 3);
    frame_in = '{8, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(1'b1, 0, 0);
    for (int k = 0; k < N; k++) checkOutput($sformatf("inv_bin0[%0d]", k), got_out[k], 1);

    // Reset during COMPUTE.
    randomFrame();
    loadFrame(1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("rst_compute");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_compute_ready", in_ready, 1);
    randomFrame();
    applyStimulus(1'b1, 0, 0);

    // Reset during UNLOAD with downstream stalled.
    randomFrame();
    loadFrame(1'b1, 0);
    waitCompute();
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("rst_unload");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_unload_ready", in_ready, 1);
    randomFrame();
    applyStimulus(1'b0, 0, 0);

    // Random frames, random direction, random flow control.
    for (int f = 0; f < 20; f++) begin
      randomFrame();
      applyStimulus(1'($urandom), $urandom_range(50), $urandom_range(60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
